// File: rtl/tile_mon_pkg.sv
// Shared types and mailbox constants for the per-core stdout/EOC monitor.
package tile_mon_pkg;

  localparam int unsigned MBOX_ERR_OFF  = 32'h0;
  localparam int unsigned MBOX_PUTC_OFF = 32'h4;
  localparam int unsigned MBOX_EOC_OFF  = 32'h8;

  localparam int unsigned MAX_ADDR_W = 64;
  localparam int unsigned MAX_DATA_W = 64;

  typedef logic [7:0] char_t;
  localparam char_t EOL = 8'h0A;

  // Widest supported bus; narrower instances zero-extend into it.
  typedef struct packed {
    logic [MAX_ADDR_W-1:0]   addr;
    logic [MAX_DATA_W-1:0]   data;
    logic [MAX_DATA_W/8-1:0] strb;
  } mon_pair_t;

  typedef enum logic {ARB_IDLE, ARB_GRANT} arb_state_t;

endpackage

// File: rtl/tile_mon_channel.sv
// One monitored core port: AW/W pairing queues, mailbox decode and char FIFO.
module tile_mon_channel
  import tile_mon_pkg::*;
#(
  parameter int unsigned       ADDR_W     = 32,
  parameter int unsigned       DATA_W     = 32,
  parameter logic [ADDR_W-1:0] MBOX_BASE  = '0,
  parameter int unsigned       PEND_DEPTH = 4,
  parameter int unsigned       CHAR_DEPTH = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                aw_valid,
  input  logic                aw_ready,
  input  logic [ADDR_W-1:0]   aw_addr,
  input  logic                w_valid,
  input  logic                w_ready,
  input  logic [DATA_W-1:0]   w_data,
  input  logic [DATA_W/8-1:0] w_strb,
  input  logic                w_last,
  input  logic                pop,
  output logic                char_avail,
  output char_t               char_head,
  output logic                char_last,
  output logic                err_valid,
  output logic [31:0]         err_code,
  output logic                eoc,
  output logic [31:0]         exit_code,
  output logic                ovf,
  output logic [15:0]         drop_cnt
);

  localparam int unsigned PW = $clog2(PEND_DEPTH);
  localparam int unsigned CW = $clog2(CHAR_DEPTH);
  localparam int unsigned SW = DATA_W / 8;
  localparam logic [ADDR_W-1:0] ERR_A  = MBOX_BASE + ADDR_W'(MBOX_ERR_OFF);
  localparam logic [ADDR_W-1:0] PUTC_A = MBOX_BASE + ADDR_W'(MBOX_PUTC_OFF);
  localparam logic [ADDR_W-1:0] EOC_A  = MBOX_BASE + ADDR_W'(MBOX_EOC_OFF);

  logic [ADDR_W-1:0]    aq [PEND_DEPTH];
  logic [DATA_W+SW-1:0] wq [PEND_DEPTH];
  char_t                cq [CHAR_DEPTH];
  logic [PW:0] aq_wr, aq_rd, wq_wr, wq_rd;
  logic [CW:0] cq_wr, cq_rd;
  logic        in_burst;
  logic        stage_v;
  mon_pair_t   stage;

  logic aw_hs, w_first, aq_empty, aq_full, wq_empty, wq_full, pair;
  logic a_pop, a_push, a_ok, d_pop, d_push, d_ok;
  logic [ADDR_W-1:0]    pair_addr;
  logic [DATA_W+SW-1:0] pair_dw;

  always_comb begin
    aw_hs    = aw_valid & aw_ready;
    w_first  = w_valid & w_ready & ~in_burst;
    aq_empty = (aq_wr == aq_rd);
    wq_empty = (wq_wr == wq_rd);
    aq_full  = (aq_wr[PW] != aq_rd[PW]) && (aq_wr[PW-1:0] == aq_rd[PW-1:0]);
    wq_full  = (wq_wr[PW] != wq_rd[PW]) && (wq_wr[PW-1:0] == wq_rd[PW-1:0]);
    pair     = (~aq_empty | aw_hs) & (~wq_empty | w_first);
    // An empty queue is bypassed: the live handshake is paired directly and never stored.
    a_pop    = pair & ~aq_empty;
    d_pop    = pair & ~wq_empty;
    a_push   = aw_hs & ~(pair & aq_empty);
    d_push   = w_first & ~(pair & wq_empty);
    a_ok     = a_push & (~aq_full | a_pop);
    d_ok     = d_push & (~wq_full | d_pop);
    pair_addr = aq_empty ? aw_addr : aq[aq_rd[PW-1:0]];
    pair_dw   = wq_empty ? {w_strb, w_data} : wq[wq_rd[PW-1:0]];
  end

  logic        lane_hi, do_err, do_putc, do_eoc, c_full, c_push;
  logic [31:0] word;
  logic [3:0]  lstrb;
  logic [ADDR_W-1:0] waddr;

  always_comb begin
    lane_hi = (DATA_W == 64) && stage.addr[2];
    word    = lane_hi ? stage.data[63:32] : stage.data[31:0];
    lstrb   = lane_hi ? stage.strb[7:4] : stage.strb[3:0];
    waddr   = {stage.addr[ADDR_W-1:2], 2'b00};
    do_err  = stage_v && (waddr == ERR_A) && (lstrb == 4'hF);
    do_putc = stage_v && (waddr == PUTC_A) && lstrb[0];
    do_eoc  = stage_v && (waddr == EOC_A) && (lstrb == 4'hF) && (word != '0) && !eoc;
    c_full  = (cq_wr[CW] != cq_rd[CW]) && (cq_wr[CW-1:0] == cq_rd[CW-1:0]);
    c_push  = do_putc && (!c_full || pop);
    char_avail = (cq_wr != cq_rd);
    char_head  = cq[cq_rd[CW-1:0]];
    char_last  = ((cq_wr - cq_rd) == (CW+1)'(1)) && !do_putc;
  end

  logic unused_stage;
  assign unused_stage = ^stage;

  always_ff @(posedge clk) begin
    if (a_ok)   aq[aq_wr[PW-1:0]] <= aw_addr;
    if (d_ok)   wq[wq_wr[PW-1:0]] <= {w_strb, w_data};
    if (c_push) cq[cq_wr[CW-1:0]] <= word[7:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      aq_wr <= '0; aq_rd <= '0; wq_wr <= '0; wq_rd <= '0;
      cq_wr <= '0; cq_rd <= '0;
      in_burst <= 1'b0; stage_v <= 1'b0; stage <= '0;
      err_valid <= 1'b0; err_code <= '0; eoc <= 1'b0; exit_code <= '0;
      ovf <= 1'b0; drop_cnt <= '0;
    end else begin
      if (w_valid && w_ready) in_burst <= ~w_last;
      if (a_ok) aq_wr <= aq_wr + 1'b1;
      if (d_ok) wq_wr <= wq_wr + 1'b1;
      if (a_pop) aq_rd <= aq_rd + 1'b1;
      if (d_pop) wq_rd <= wq_rd + 1'b1;
      if ((a_push && !a_ok) || (d_push && !d_ok)) ovf <= 1'b1;
      stage_v     <= pair;
      stage.addr  <= MAX_ADDR_W'(pair_addr);
      stage.data  <= MAX_DATA_W'(pair_dw[DATA_W-1:0]);
      stage.strb  <= (MAX_DATA_W/8)'(pair_dw[DATA_W+SW-1:DATA_W]);
      if (do_err) begin err_code <= word; err_valid <= 1'b1; end
      if (do_eoc) begin exit_code <= word; eoc <= 1'b1; end
      if (c_push) cq_wr <= cq_wr + 1'b1;
      if (pop)    cq_rd <= cq_rd + 1'b1;
      if (do_putc && !c_push && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
    end
  end

endmodule

// File: rtl/tile_stdout_eoc_monitor.sv
// Per-core mailbox monitor with a round-robin (optionally line-atomic) stdout merger.
module tile_stdout_eoc_monitor
  import tile_mon_pkg::*;
#(
  parameter int unsigned       N_CH       = 4,
  parameter int unsigned       ADDR_W     = 32,
  parameter int unsigned       DATA_W     = 32,
  parameter logic [ADDR_W-1:0] MBOX_BASE  = ADDR_W'(32'h2FFF_0000),
  parameter int unsigned       PEND_DEPTH = 4,
  parameter int unsigned       CHAR_DEPTH = 64,
  parameter int unsigned       LINE_MODE  = 1,
  localparam int unsigned      CH_W       = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [N_CH-1:0]            aw_valid_i,
  input  logic [N_CH-1:0]            aw_ready_i,
  input  logic [N_CH*ADDR_W-1:0]     aw_addr_i,
  input  logic [N_CH-1:0]            w_valid_i,
  input  logic [N_CH-1:0]            w_ready_i,
  input  logic [N_CH*DATA_W-1:0]     w_data_i,
  input  logic [N_CH*DATA_W/8-1:0]   w_strb_i,
  input  logic [N_CH-1:0]            w_last_i,
  output logic                       char_valid_o,
  input  logic                       char_ready_i,
  output logic [CH_W-1:0]            char_ch_o,
  output logic [7:0]                 char_data_o,
  output logic [N_CH-1:0]            err_valid_o,
  output logic [N_CH*32-1:0]         err_code_o,
  output logic [N_CH-1:0]            eoc_o,
  output logic [N_CH*32-1:0]         exit_code_o,
  output logic                       all_eoc_o,
  output logic [N_CH-1:0]            ovf_o,
  output logic [N_CH*16-1:0]         drop_cnt_o
);

  logic [N_CH-1:0] avail, last, pop;
  char_t           head [N_CH];

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    tile_mon_channel #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MBOX_BASE(MBOX_BASE),
      .PEND_DEPTH(PEND_DEPTH), .CHAR_DEPTH(CHAR_DEPTH)
    ) u_ch (
      .clk(clk_i), .rst(rst_i),
      .aw_valid(aw_valid_i[g]), .aw_ready(aw_ready_i[g]),
      .aw_addr(aw_addr_i[g*ADDR_W +: ADDR_W]),
      .w_valid(w_valid_i[g]), .w_ready(w_ready_i[g]),
      .w_data(w_data_i[g*DATA_W +: DATA_W]),
      .w_strb(w_strb_i[g*(DATA_W/8) +: DATA_W/8]),
      .w_last(w_last_i[g]), .pop(pop[g]),
      .char_avail(avail[g]), .char_head(head[g]), .char_last(last[g]),
      .err_valid(err_valid_o[g]), .err_code(err_code_o[g*32 +: 32]),
      .eoc(eoc_o[g]), .exit_code(exit_code_o[g*32 +: 32]),
      .ovf(ovf_o[g]), .drop_cnt(drop_cnt_o[g*16 +: 16])
    );
  end

  assign all_eoc_o = &eoc_o;

  arb_state_t      state;
  logic [CH_W-1:0] rr, gch, pick, sel, next_rr;
  logic            pick_v, fire, release_ch;
  int unsigned     k;

  // IDLE offers the pick combinationally so a char can leave the cycle it lands;
  // GRANT is entered whenever the offer is not finished, which keeps the head stable.
  always_comb begin
    pick_v = 1'b0;
    pick   = '0;
    k      = 0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      k = (32'(rr) + i) % N_CH;
      if (!pick_v && avail[CH_W'(k)]) begin
        pick_v = 1'b1;
        pick   = CH_W'(k);
      end
    end
    sel          = (state == ARB_GRANT) ? gch : pick;
    char_valid_o = (state == ARB_GRANT) || pick_v;
    char_data_o  = head[sel];
    char_ch_o    = sel;
    fire         = char_valid_o && char_ready_i;
    release_ch   = (LINE_MODE == 0) || (head[sel] == EOL) || last[sel];
    next_rr      = (sel == CH_W'(N_CH-1)) ? '0 : sel + CH_W'(1);
    pop          = '0;
    for (int unsigned i = 0; i < N_CH; i++) pop[i] = fire && (sel == CH_W'(i));
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= ARB_IDLE;
      rr    <= '0;
      gch   <= '0;
    end else begin
      case (state)
        ARB_IDLE:
          if (pick_v) begin
            if (fire && release_ch) rr <= next_rr;
            else begin
              state <= ARB_GRANT;
              gch   <= pick;
            end
          end
        ARB_GRANT:
          if (fire && release_ch) begin
            rr    <= next_rr;
            state <= ARB_IDLE;
          end
        default: state <= ARB_IDLE;
      endcase
    end
  end

endmodule
